// File: rtl/clk_div_pkg.sv
// Shared types, defaults and configuration validation for the multi-channel clock divider.
package clk_div_pkg;

    parameter int DIV_W_DEF = 16;

    typedef struct packed {
        logic [DIV_W_DEF-1:0] period;
        logic [DIV_W_DEF-1:0] high;
    } div_cfg_t;

    localparam div_cfg_t DEFAULT_CFG = '{period: 16'd4, high: 16'd2};

    // A configuration needs at least one high and one low cycle per period.
    function automatic logic cfg_valid(input logic [31:0] period, input logic [31:0] high);
        return (period >= 32'd2) && (high >= 32'd1) && (high < period);
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: phase counter, active/staged configuration and registered outputs.
module clk_div_channel #(
    parameter int DIV_W          = 16,
    parameter int DEFAULT_PERIOD = 4,
    parameter int DEFAULT_HIGH   = 2
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_period,
    input  logic [DIV_W-1:0] wr_high,
    output logic             clk_out,
    output logic             tick,
    output logic             cfg_pending
);

    typedef struct packed {
        logic [DIV_W-1:0] period;
        logic [DIV_W-1:0] high;
    } ch_cfg_t;

    localparam ch_cfg_t RESET_CFG = '{period: DIV_W'(DEFAULT_PERIOD), high: DIV_W'(DEFAULT_HIGH)};

    ch_cfg_t          act_r;
    ch_cfg_t          stg_r;
    logic [DIV_W-1:0] cnt_r;
    logic             pending_r;
    logic             clk_out_r;
    logic             tick_r;
    logic             wrap_s;
    logic             restart_s;

    // Period boundary detection; sync acts as an early boundary.
    always_comb begin
        wrap_s    = (cnt_r == (act_r.period - DIV_W'(1)));
        restart_s = sync | wrap_s;
    end

    // Counter, configuration staging/application and output registers.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            act_r     <= RESET_CFG;
            stg_r     <= '{period: {DIV_W{1'b0}}, high: {DIV_W{1'b0}}};
            cnt_r     <= {DIV_W{1'b0}};
            pending_r <= 1'b0;
            clk_out_r <= 1'b0;
            tick_r    <= 1'b0;
        end else if (!en) begin
            // Idle channel: nothing in flight, so configuration takes effect at once.
            cnt_r     <= {DIV_W{1'b0}};
            clk_out_r <= 1'b0;
            tick_r    <= 1'b0;
            pending_r <= 1'b0;
            if (wr) begin
                act_r <= '{period: wr_period, high: wr_high};
            end else if (pending_r) begin
                act_r <= stg_r;
            end
        end else begin
            if (sync) begin
                cnt_r     <= {DIV_W{1'b0}};
                clk_out_r <= 1'b0;
                tick_r    <= 1'b0;
            end else begin
                clk_out_r <= (cnt_r < act_r.high);
                tick_r    <= (cnt_r == {DIV_W{1'b0}});
                cnt_r     <= wrap_s ? {DIV_W{1'b0}} : (cnt_r + DIV_W'(1));
            end
            if (restart_s && pending_r) begin
                act_r <= stg_r;
            end
            // A load landing on a boundary is kept for the next boundary.
            if (wr) begin
                stg_r     <= '{period: wr_period, high: wr_high};
                pending_r <= 1'b1;
            end else if (restart_s) begin
                pending_r <= 1'b0;
            end
        end
    end

    assign clk_out     = clk_out_r;
    assign tick        = tick_r;
    assign cfg_pending = pending_r;

endmodule

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider: load decode/validation and channel array.
module multi_clock_divider
    import clk_div_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int DIV_W          = DIV_W_DEF,
    parameter int DEFAULT_PERIOD = int'(DEFAULT_CFG.period),
    parameter int DEFAULT_HIGH   = int'(DEFAULT_CFG.high),
    localparam int CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic [N_CH-1:0]  en,
    input  logic             sync,
    input  logic             load,
    input  logic [CH_W-1:0]  load_ch,
    input  logic [DIV_W-1:0] load_period,
    input  logic [DIV_W-1:0] load_high,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  cfg_pending,
    output logic             cfg_err
);

    logic            ch_ok_s;
    logic            valid_s;
    logic            err_s;
    logic [N_CH-1:0] wr_s;
    logic            cfg_err_r;

    // Validate the load and steer it to exactly one channel.
    always_comb begin
        ch_ok_s = (32'(load_ch) < 32'(N_CH));
        valid_s = load & ch_ok_s & cfg_valid(32'(load_period), 32'(load_high));
        err_s   = load & ~valid_s;
        wr_s    = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            wr_s[i] = valid_s & (32'(load_ch) == 32'(i));
        end
    end

    // Rejected-load flag, a single-cycle pulse after the offending load.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= err_s;
        end
    end

    assign cfg_err = cfg_err_r;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clk_div_channel #(
            .DIV_W          (DIV_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD),
            .DEFAULT_HIGH   (DEFAULT_HIGH)
        ) u_ch (
            .clk_in      (clk_in),
            .reset_n     (reset_n),
            .en          (en[g]),
            .sync        (sync),
            .wr          (wr_s[g]),
            .wr_period   (load_period),
            .wr_high     (load_high),
            .clk_out     (clk_out[g]),
            .tick        (tick[g]),
            .cfg_pending (cfg_pending[g])
        );
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed plus randomized bench for multi_clock_divider, checked every cycle against a phase model.
`timescale 1ns/100ps
module tb_multi_clock_divider;

    localparam int NC = 5;   // five channels so that load_ch values 5..7 are out of range
    localparam int DW = 16;

    logic          clk_in = 1'b0;
    logic          reset_n = 1'b0;
    logic [NC-1:0] en = '0;
    logic          sync = 1'b0;
    logic          load = 1'b0;
    logic [2:0]    load_ch = '0;
    logic [DW-1:0] load_period = '0;
    logic [DW-1:0] load_high = '0;
    logic [NC-1:0] clk_out;
    logic [NC-1:0] tick;
    logic [NC-1:0] cfg_pending;
    logic          cfg_err;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: phase within period, active and staged configuration per channel.
    int m_per[NC], m_hi[NC], m_sp[NC], m_sh[NC], m_ph[NC];
    bit m_pend[NC], m_clk[NC], m_tick[NC];
    bit m_err;

    multi_clock_divider #(.N_CH(NC), .DIV_W(DW)) dut (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
        .en          (en),
        .sync        (sync),
        .load        (load),
        .load_ch     (load_ch),
        .load_period (load_period),
        .load_high   (load_high),
        .clk_out     (clk_out),
        .tick        (tick),
        .cfg_pending (cfg_pending),
        .cfg_err     (cfg_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_per[i] = 4; m_hi[i] = 2; m_sp[i] = 0; m_sh[i] = 0; m_ph[i] = 0;
            m_pend[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
        end
        m_err = 0;
    endtask

    task automatic model_step();
        int p, h;
        bit ok, wr, bnd;
        p = int'(load_period);
        h = int'(load_high);
        ok = load && (int'(load_ch) < NC) && (p >= 2) && (h >= 1) && (h < p);
        m_err = load && !ok;
        for (int i = 0; i < NC; i++) begin
            wr = ok && (int'(load_ch) == i);
            if (!en[i]) begin
                m_clk[i] = 0; m_tick[i] = 0; m_ph[i] = 0;
                if (wr) begin m_per[i] = p; m_hi[i] = h; end
                else if (m_pend[i]) begin m_per[i] = m_sp[i]; m_hi[i] = m_sh[i]; end
                m_pend[i] = 0;
            end else begin
                bnd = sync || (m_ph[i] + 1 == m_per[i]);
                if (sync) begin
                    m_clk[i] = 0; m_tick[i] = 0; m_ph[i] = 0;
                end else begin
                    m_clk[i] = (m_ph[i] < m_hi[i]);
                    m_tick[i] = (m_ph[i] == 0);
                    m_ph[i] = (m_ph[i] + 1) % m_per[i];
                end
                if (bnd && m_pend[i]) begin m_per[i] = m_sp[i]; m_hi[i] = m_sh[i]; end
                if (wr) begin m_sp[i] = p; m_sh[i] = h; m_pend[i] = 1; end
                else if (bnd) m_pend[i] = 0;
            end
        end
    endtask

    task automatic check_outputs();
        logic [NC-1:0] ec, et, ep;
        for (int i = 0; i < NC; i++) begin
            ec[i] = m_clk[i]; et[i] = m_tick[i]; ep[i] = m_pend[i];
        end
        check_val("clk_out", 32'(clk_out), 32'(ec));
        check_val("tick", 32'(tick), 32'(et));
        check_val("cfg_pending", 32'(cfg_pending), 32'(ep));
        check_val("cfg_err", 32'(cfg_err), 32'(m_err));
    endtask

    // Advance one clock: model sees the same inputs as the DUT edge, outputs checked mid-cycle.
    task automatic cycle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_in);
            if (reset_n) model_step();
            @(negedge clk_in);
            check_outputs();
        end
    endtask

    task automatic do_load(input int ch, input int p, input int h);
        load = 1'b1; load_ch = 3'(ch); load_period = DW'(p); load_high = DW'(h);
        cycle(1);
        load = 1'b0;
    endtask

    initial begin
        model_reset();
        #3;
        check_outputs();
        cycle(3);
        reset_n = 1'b1;
        cycle(1);

        // Default P=4,H=2 on channel 0.
        en = 5'b00001;
        cycle(12);

        // Disabled channel 1 takes its config immediately, then runs 10000.
        do_load(1, 5, 1);
        cycle(3);
        en = 5'b00011;
        cycle(12);

        // Mid-period reconfiguration of running channel 0 to P=6,H=3.
        do_load(0, 6, 3);
        cycle(14);

        // Rejected loads.
        do_load(0, 1, 1);  cycle(2);
        do_load(0, 6, 0);  cycle(2);
        do_load(0, 8, 8);  cycle(2);
        do_load(5, 4, 2);  cycle(2);
        do_load(7, 4, 2);  cycle(2);

        // Channels 0 (P=4) and 2 (P=6) out of phase, then sync aligns them.
        do_load(0, 4, 2);
        do_load(2, 6, 3);
        cycle(7);
        en = 5'b00101;
        cycle(9);
        sync = 1'b1;
        cycle(1);
        sync = 1'b0;
        cycle(1);
        check_val("sync_tick_align", 32'(tick & 5'b00101), 32'h5);
        cycle(24);

        // Load coinciding with sync: staged, not applied by this sync.
        sync = 1'b1;
        do_load(2, 3, 1);
        sync = 1'b0;
        cycle(10);

        // Async reset during a high phase with P=6 active.
        do_load(0, 6, 3);
        cycle(8);
        for (int k = 0; k < 20 && !clk_out[0]; k++) cycle(1);
        check_val("reach_high", 32'(clk_out[0]), 32'h1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #0.5;
        check_outputs();
        #0.5;
        reset_n = 1'b1;
        cycle(12);

        // Randomized operation.
        for (int k = 0; k < 3000; k++) begin
            int p;
            if ($urandom_range(39, 0) == 0) en = NC'($urandom);
            sync = ($urandom_range(24, 0) == 0);
            load = ($urandom_range(4, 0) == 0);
            load_ch = 3'($urandom_range(7, 0));
            p = int'($urandom_range(12, 0));
            load_period = DW'(p);
            load_high = DW'($urandom_range(p + 1, 0));
            cycle(1);
        end
        sync = 1'b0;
        load = 1'b0;
        cycle(4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/multi_clock_divider.md
Name: multi_clock_divider

Overview:
- Multi-channel, runtime-programmable clock divider. It is the successor to the fixed single-channel toggle divider.
- Each channel produces a divided clock-enable style waveform with programmable period and high time, plus a one-cycle tick at each period start.
- A shared sync input phase-aligns all channels.
- Sits between the board clock and slow peripherals (display scan, debouncers, UART baud) and is configured by a control FSM or register block.

Parameters:
- N_CH, 4, number of independent divider channels (>=1).
- DIV_W, 16, width of period/high-time fields; max period 2^DIV_W-1.
- DEFAULT_PERIOD, 4, reset period for every channel (2..2^DIV_W-1).
- DEFAULT_HIGH, 2, reset high time (1..DEFAULT_PERIOD-1).

Ports:
- clk_in  input  1  system clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  N_CH  per-channel run enable.
- sync  input  1  pulse; restarts all enabled channels at phase 0.
- load  input  1  pulse; write config to channel load_ch.
- load_ch  input  max(1,$clog2(N_CH))  target channel of load.
- load_period  input  DIV_W  new period P in clk_in cycles.
- load_high  input  DIV_W  new high time H in cycles.
- clk_out  output  N_CH  divided waveform, registered.
- tick  output  N_CH  one-cycle pulse at period start, registered.
- cfg_pending  output  N_CH  staged config not yet applied.
- cfg_err  output  1  one-cycle pulse: last load rejected.

Behaviour:
- Reset (async assert, sync release): cnt=0, clk_out=0, tick=0, cfg_pending=0, cfg_err=0, active P=DEFAULT_PERIOD, H=DEFAULT_HIGH, staging cleared.
- Per channel, en=1 and no sync: clk_out <= (cnt < H); tick <= (cnt == 0); cnt <= (cnt == P-1) ? 0 : cnt+1.
- Output period is exactly P cycles. High for H cycles, low for P-H cycles.
- First clk_out/tick high occurs one cycle after en is first sampled high.
- en=0: cnt held at 0, clk_out <= 0, tick <= 0 next edge. Re-enabling restarts at phase 0.
- Load validation is combinational on the load cycle. A load is valid iff P>=2, H>=1 and H<P.
- Invalid load: staging unchanged, cfg_err=1 next cycle only. load_ch >= N_CH is also invalid.
- Valid load to an enabled channel: written to staging, cfg_pending[ch]=1 next cycle.
- Staged config is applied on the edge where cnt == P-1 (period boundary, glitch-free). From the following cycle cnt=0 uses the new P/H. cfg_pending clears on the same edge.
- Valid load to a disabled channel: applied immediately (active P/H updated next edge). cfg_pending stays 0.
- A second load before application overwrites staging (last wins). cfg_pending stays 1.
- Load coinciding with the boundary edge: the new value is staged and pending. The boundary applies only the previously staged value.
- sync=1 on an edge: every enabled channel sets cnt<=0, clk_out<=0, tick<=0, and applies any staged config. The next cycle behaves as phase 0 (tick=1).
- sync has priority over boundary wrap. Disabled channels ignore sync.
- Counter arithmetic is DIV_W wide, unsigned. No overflow is possible because cnt<P.
- Mid-operation reset_n low: all state returns to reset values immediately (async), including active config.

Decomposition:
- Package clk_div_pkg: typedef struct packed {logic [DIV_W-1:0] period, high;} div_cfg_t. Also functions cfg_valid() and DEFAULT_CFG, parametrised via package parameter DIV_W_DEF=16.
- Sub-module clk_div_channel: one counter, active/staged cfg, pending flag, clk_out/tick generation.
- Top instantiates N_CH channels via generate, decodes load_ch, validates, drives cfg_err.

Test Plan:
- Reset then en=4'b0001, defaults P=4,H=2 -> clk_out[0] pattern 1100 repeating starting one cycle after en; tick[0] every 4 cycles; other channels 0.
- Channel 1 disabled, load P=5,H=1 -> cfg_pending[1] stays 0; enable -> clk_out[1] = 10000 repeating.
- Channel 0 running P=4, load P=6,H=3 mid-period -> cfg_pending[0]=1 until cnt==3 edge; next period 111000; no short/long pulse at transition.
- Loads P=1 / H=0 / H=P=8 / load_ch=5 (N_CH=4) -> cfg_err pulses 1 cycle each; waveforms unchanged.
- Channels 0 (P=4) and 2 (P=6) free-running out of phase; pulse sync -> both tick together next cycle; edges aligned every 12 cycles.
- reset_n low for 1 ns mid-high phase with P=6 loaded -> clk_out=0 immediately; after release, channel runs defaults P=4,H=2.
